// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver FSM state type and line/frame constants.
// Used by uart_line_rx; the PARITY state is only entered when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;
    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_line_rx_if.sv
// uart_line_rx_if: received-byte stream handshake.
// Ports: rx_data (head byte), rx_valid (byte available), rx_ready (consumer pop).
// master = receiver side, slave = consumer side.
interface uart_line_rx_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO for received bytes.
// Ports: clk, Presetn (sync active-low), push/din write, pop read, dout head (0 when empty), full, empty.
// A push on full is accepted only when a real pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Presetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!Presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: oversampled UART line receiver with byte FIFO and error flags.
// Ports: clk, Presetn (sync active-low), baud_o (oversample tick), TXD (async serial line),
//   rx (uart_line_rx_if.master byte stream), frame_err/parity_err (1-clk pulses),
//   overflow (sticky, cleared by ovf_clr), rx_busy (FSM not idle).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_line_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           Presetn,
    input  logic           baud_o,
    input  logic           TXD,
    uart_line_rx_if.master rx,
    output logic           frame_err,
    output logic           parity_err,
    output logic           overflow,
    input  logic           ovf_clr,
    output logic           rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic line, last, push, pop, full, empty, byte_ok;
`ifdef UART_RX_PARITY_EN
    logic perr;
    assign byte_ok = !perr;
`else
    assign byte_ok = 1'b1;
    assign parity_err = 1'b0;
`endif
    assign line = sync[1];
    assign last = cnt == CW'(OVERSAMPLE - 1);
    // Push is combinational at the stop-sample tick so the byte is visible one cycle later.
    assign push = baud_o && state == STOP && last && line == IDLE_LEVEL && byte_ok;
    assign pop = rx.rx_valid && rx.rx_ready;
    assign rx.rx_valid = !empty;
    assign rx_busy = state != IDLE;
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk(clk),
        .Presetn(Presetn),
        .push(push),
        .pop(pop),
        .din(shreg),
        .dout(rx.rx_data),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (!Presetn) begin
            sync <= {2{IDLE_LEVEL}};
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            frame_err <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync <= {sync[0], TXD};
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A drop in the same cycle as ovf_clr keeps the flag set.
            overflow <= (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
            if (baud_o) begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        state <= line != IDLE_LEVEL ? START : IDLE;
                    end
                    START: begin
                        cnt <= cnt == CW'(OVERSAMPLE / 2 - 1) ? '0 : cnt + 1'b1;
                        bit_idx <= '0;
                        if (cnt == CW'(OVERSAMPLE / 2 - 1)) state <= line == IDLE_LEVEL ? IDLE : DATA;
                    end
                    DATA: begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            shreg <= {line, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == BW'(DATA_BITS - 1)) state <= AFTER_DATA;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            perr <= line != ^shreg;
                            state <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            frame_err <= line != IDLE_LEVEL;
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err <= perr;
                            perr <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: directed frames against a frame-level model (event ticks + byte queue).
module tb_uart_line_rx;
    import uart_rx_pkg::*;
    localparam int OS = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    typedef struct {
        int t;
        logic good;
        logic [7:0] d;
        logic fe;
        logic pe;
    } ev_t;

    logic clk = 0, Presetn = 0, baud_o = 0, TXD = 1, ovf_clr = 0, ready = 0, run = 0;
    logic frame_err, parity_err, overflow, rx_busy;
    int checks = 0, errors = 0, n_ticks = 0, m_ticks = 0;
    int fe_cnt = 0, pe_cnt = 0, valid_cnt = 0;
    logic [7:0] popped[$];
    logic [7:0] mq[$];
    ev_t evq[$];
    logic m_ovf = 0, exp_fe = 0, exp_pe = 0;

    uart_line_rx_if rxi();
    assign rxi.rx_ready = ready;

    uart_line_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .Presetn(Presetn),
        .baud_o(baud_o),
        .TXD(TXD),
        .rx(rxi),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a byte or error appears at the stop-sample tick, which lies
    // 1 tick (synchronizer) + half a bit + one bit per data/parity/stop slot after the
    // tick at which the bench drove the start bit.
    always @(posedge clk) begin : model
        logic pop_m, drop;
        ev_t e;
        if (!Presetn) begin
            mq.delete();
            evq.delete();
            m_ovf = 0;
            exp_fe = 0;
            exp_pe = 0;
        end else begin
            pop_m = ready && mq.size() > 0;
            drop = 0;
            exp_fe = 0;
            exp_pe = 0;
            if (baud_o) begin
                if (evq.size() > 0 && evq[0].t == m_ticks) begin
                    e = evq.pop_front();
                    exp_fe = e.fe;
                    exp_pe = e.pe;
                    if (e.good) begin
                        if (mq.size() == DEPTH && !pop_m) drop = 1;
                        else mq.push_back(e.d);
                    end
                end
                m_ticks++;
            end
            if (pop_m) void'(mq.pop_front());
            m_ovf = drop ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("cyc_valid", rxi.rx_valid, mq.size() > 0);
            chk("cyc_data", rxi.rx_data, mq.size() > 0 ? mq[0] : 8'h00);
            chk("cyc_frame_err", frame_err, exp_fe);
            chk("cyc_parity_err", parity_err, exp_pe);
            chk("cyc_overflow", overflow, m_ovf);
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (rxi.rx_valid) valid_cnt++;
            if (rxi.rx_valid && ready) popped.push_back(rxi.rx_data);
        end
    end

    task automatic ticks(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 baud_o = 1;
            @(posedge clk);
            #1 baud_o = 0;
            TXD = v;
            n_ticks++;
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop);
        ev_t e;
        e.t = n_ticks + 1 + OS / 2 + OS * (9 + PB);
        e.d = d;
        e.fe = !stop;
        e.pe = (PB == 1) && (par != ^d);
        e.good = stop && !e.pe;
        evq.push_back(e);
        ticks(0, OS);
        for (int i = 0; i < 8; i++) ticks(d[i], OS);
        if (PB == 1) ticks(par, OS);
        ticks(stop, OS);
        ticks(1, 12);
    endtask

    task automatic clear_counts();
        fe_cnt = 0;
        pe_cnt = 0;
        valid_cnt = 0;
        popped.delete();
    endtask

    initial begin
        logic [7:0] ab;
        repeat (3) @(posedge clk);
        #1 run = 1;
        chk("rst_valid", rxi.rx_valid, 0);
        chk("rst_data", rxi.rx_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", rx_busy, 0);
        Presetn = 1;
        ticks(1, 8);

        ready = 1;
        clear_counts();
        send(8'hA5, 1'b0, 1'b1);
        chk("a5_valid_cycles", valid_cnt, 1);
        chk("a5_pops", popped.size(), 1);
        if (popped.size() > 0) chk("a5_data", popped[0], 8'hA5);
        chk("a5_errs", fe_cnt + pe_cnt, 0);

        clear_counts();
        send(8'h3C, 1'b0, 1'b0);
        chk("3c_frame_err", fe_cnt, 1);
        chk("3c_valid_cycles", valid_cnt, 0);

`ifdef UART_RX_PARITY_EN
        clear_counts();
        send(8'h01, 1'b0, 1'b1);
        chk("01_parity_err", pe_cnt, 1);
        chk("01_frame_err", fe_cnt, 0);
        chk("01_valid_cycles", valid_cnt, 0);
`endif

        clear_counts();
        ticks(0, 4);
        #2 chk("glitch_busy_hi", rx_busy, 1);
        ticks(1, 12);
        #2 chk("glitch_busy_lo", rx_busy, 0);
        chk("glitch_valid_cycles", valid_cnt, 0);
        chk("glitch_errs", fe_cnt + pe_cnt, 0);

        ready = 0;
        clear_counts();
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1);
        #2 chk("ovf_set", overflow, 1);
        ready = 1;
        repeat (8) @(posedge clk);
        #1 ready = 0;
        chk("ovf_pops", popped.size(), 4);
        for (int i = 0; i < popped.size(); i++) chk("ovf_pop_data", popped[i], 8'h10 + i);
        @(posedge clk);
        #1 ovf_clr = 1;
        @(posedge clk);
        #1 ovf_clr = 0;
        chk("ovf_clr", overflow, 0);

        ready = 1;
        clear_counts();
        ab = 8'h35;
        ticks(0, OS);
        for (int i = 0; i < 4; i++) ticks(ab[i], OS);
        ticks(ab[4], OS / 2);
        #2 chk("abort_busy", rx_busy, 1);
        @(posedge clk);
        #1 Presetn = 0;
        @(posedge clk);
        #1 Presetn = 1;
        chk("abort_busy_rst", rx_busy, 0);
        chk("abort_valid_rst", rxi.rx_valid, 0);
        chk("abort_data_rst", rxi.rx_data, 0);
        chk("abort_ovf_rst", overflow, 0);
        ticks(1, 20);
        chk("abort_no_push", valid_cnt, 0);
        chk("abort_no_err", fe_cnt + pe_cnt, 0);
        send(8'h5A, ^8'h5A, 1'b1);
        chk("5a_pops", popped.size(), 1);
        if (popped.size() > 0) chk("5a_data", popped[0], 8'h5A);
        chk("5a_errs", fe_cnt + pe_cnt, 0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving baud-tick pulses per bit period.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), giving received-byte buffer entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port Presetn, input, 1, reset; it is synchronous and active-low.
REQ-005 SHALL have port baud_o, input, 1, a one-clk-wide oversample tick at OVERSAMPLE x baud rate.
REQ-006 SHALL have port TXD, input, 1, the asynchronous serial line (idle high) from the UART core.
REQ-007 SHALL have port rx_data, output, 8, the FIFO head byte.
REQ-008 SHALL have port rx_valid, output, 1, high when the FIFO is non-empty.
REQ-009 SHALL have port rx_ready, input, 1, consumer pop request.
REQ-010 SHALL have port frame_err, output, 1, a one-clk pulse when a stop bit samples low.
REQ-011 SHALL have port parity_err, output, 1, a one-clk pulse on parity mismatch (held 0 when parity is compiled out).
REQ-012 SHALL have port overflow, output, 1, sticky high when a good byte is dropped because the FIFO is full.
REQ-013 SHALL have port ovf_clr, input, 1, which clears overflow.
REQ-014 SHALL have port rx_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass TXD through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-016 SHALL advance the FSM and the tick counter only on clk cycles where baud_o=1.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on a tick with line low; tick counter cleared.
REQ-019 In START, at tick OVERSAMPLE/2 (mid-bit): if line high -> IDLE (false start, no error); else -> DATA with counter cleared.
REQ-020 In DATA, SHALL sample every OVERSAMPLE ticks, 8 bits, LSB first, then -> PARITY if compiled in, else -> STOP.
REQ-021 In PARITY, SHALL sample one bit after OVERSAMPLE ticks and compare it against the even parity of the 8 data bits.
REQ-022 In STOP, SHALL sample after OVERSAMPLE ticks and then return to IDLE; line low -> frame_err pulse and byte discarded.
REQ-023 A byte with a parity error SHALL be discarded and pulse parity_err; parity_err and frame_err may pulse together.
REQ-024 A good byte SHALL be pushed at the stop-sample cycle; rx_valid/rx_data are visible the following cycle (1-clk latency, no bypass).
REQ-025 Pop SHALL occur on a cycle where rx_valid && rx_ready; rx_data then shows the next entry the following cycle.
REQ-026 Push on full without a same-cycle pop SHALL drop the byte and set overflow; push with a same-cycle pop on full SHALL be accepted.
REQ-027 Pop when empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 ovf_clr SHALL clear overflow next cycle; a simultaneous overflow event SHALL win (overflow stays 1).
REQ-029 rx_ready SHALL never affect the FSM; the FSM never stalls.

Reset
REQ-030 Presetn=0 at a posedge SHALL force: FSM IDLE, counters 0, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overflow=0, rx_busy=0, synchronizer flops=1.
REQ-031 Reset mid-frame SHALL abandon the frame; no push and no error pulse.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: PARITY state present per REQ-021/023; frame = start + 8 data + parity + stop.
REQ-033 Macro UART_RX_PARITY_EN undefined: no PARITY state, parity_err tied 0; frame = start + 8 data + stop.

Structure
REQ-034 Package uart_rx_pkg SHALL hold the FSM state enum typedef and the constants DATA_BITS=8 and IDLE_LEVEL=1'b1.
REQ-035 Buffering SHALL be a sub-module uart_rx_fifo (synchronous FIFO with push, pop, full, empty, and dout ports).

Verification
REQ-036 Frame 0xA5 (even parity 0), good stop, rx_ready=1 -> rx_valid for exactly 1 clk with rx_data=0xA5, no errors.
REQ-037 Stop bit forced low on 0x3C -> frame_err for 1 clk, rx_valid stays 0.
REQ-038 (UART_RX_PARITY_EN) 0x01 sent with parity bit 0 -> parity_err for 1 clk, no push.
REQ-039 Low glitch of 4 ticks on idle line -> return to IDLE, rx_busy deasserts, no push, no errors.
REQ-040 rx_ready=0, 5 good bytes 0x10..0x14 -> overflow=1, FIFO pops 0x10..0x13 in order; ovf_clr -> overflow=0.
REQ-041 Presetn low for one cycle during DATA bit 4 -> all outputs at reset values; the next full frame 0x5A is received correctly.
